// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester memory port arbiter with round-robin ties and a bounded hold time
// Owner state drives the shared memory bus combinationally; grants, read data and read-valid pulses are registered.
module mem_port_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic       we0,
  input  logic [7:0] wdata0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic       we1,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rdValid0,
  output logic       rdValid1,
  output logic [7:0] rdata,
  output logic [7:0] memAddr,
  output logic       memWe,
  output logic [7:0] memWdata,
  input  logic [7:0] memVal
);

  localparam logic [3:0] HOLD_LIM = MAX_HOLD[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       armed;
  logic       last_owner;
  logic [3:0] count;
  logic [3:0] count_inc;
  logic       hold_hit;
  logic       xfer0;
  logic       xfer1;
  logic       read0;
  logic       read1;

  assign xfer0     = (state == OWN0) && req0;
  assign xfer1     = (state == OWN1) && req1;
  assign read0     = xfer0 && !we0;
  assign read1     = xfer1 && !we1;
  assign count_inc = (count == 4'd15) ? 4'd15 : count + 4'd1;
  // Compared with >= so an owner that ran long while alone yields right after the other side shows up.
  assign hold_hit  = (count_inc >= HOLD_LIM);

  always_comb begin
    memAddr  = 8'h00;
    memWe    = 1'b0;
    memWdata = 8'h00;
    if (xfer0) begin
      memAddr  = addr0;
      memWe    = we0;
      memWdata = wdata0;
    end else if (xfer1) begin
      memAddr  = addr1;
      memWe    = we1;
      memWdata = wdata1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        // armed holds off the first grant until the second edge after reset release.
        if (armed) begin
          if (req0 && req1)  state_nx = last_owner ? OWN0 : OWN1;
          else if (req0)     state_nx = OWN0;
          else if (req1)     state_nx = OWN1;
        end
      end
      OWN0: begin
        if (!req0)                 state_nx = req1 ? OWN1 : IDLE;
        else if (req1 && hold_hit) state_nx = OWN1;
      end
      OWN1: begin
        if (!req1)                 state_nx = req0 ? OWN0 : IDLE;
        else if (req0 && hold_hit) state_nx = OWN0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      last_owner <= 1'b1;
      count      <= 4'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rdValid0   <= 1'b0;
      rdValid1   <= 1'b0;
      rdata      <= 8'h00;
    end else begin
      armed    <= 1'b1;
      state    <= state_nx;
      gnt0     <= (state_nx == OWN0);
      gnt1     <= (state_nx == OWN1);
      rdValid0 <= read0;
      rdValid1 <= read1;
      if (read0 || read1) rdata <= memVal;
      if ((state_nx != state) && (state_nx != IDLE)) begin
        count      <= 4'd0;
        last_owner <= (state_nx == OWN1);
      end else if (xfer0 || xfer1) begin
        count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a behavioural model
module tb_mem_port_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, rdValid0, rdValid1, memWe;
  logic [7:0] rdata, memAddr, memWdata, memVal;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  int         m_owner = -1;
  int         m_run = 0;
  int         m_last = 1;
  bit         m_armed = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  bit         m_rdv [2] = '{1'b0, 1'b0};
  bit         m_xfer [2] = '{1'b0, 1'b0};

  mem_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdValid0(rdValid0), .rdValid1(rdValid1),
    .rdata(rdata), .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata),
    .memVal(memVal)
  );

  always #5 clk = ~clk;

  assign memVal = mem[memAddr];

  always @(posedge clk) if (memWe) mem[memAddr] = memWdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1; m_armed = 1'b0; m_rdata = 8'h00;
    m_rdv = '{1'b0, 1'b0}; m_xfer = '{1'b0, 1'b0};
  endtask

  task automatic model_step();
    bit         r [2];
    bit         w [2];
    logic [7:0] a [2];
    logic [7:0] d [2];
    int         nxt;
    r = '{req0, req1}; w = '{we0, we1}; a = '{addr0, addr1}; d = '{wdata0, wdata1};
    m_rdv = '{1'b0, 1'b0};
    m_xfer = '{1'b0, 1'b0};
    if (m_owner >= 0 && r[m_owner]) begin
      m_xfer[m_owner] = 1'b1;
      if (w[m_owner]) ref_mem[a[m_owner]] = d[m_owner];
      else begin
        m_rdata = ref_mem[a[m_owner]];
        m_rdv[m_owner] = 1'b1;
      end
      m_run = (m_run < 15) ? m_run + 1 : 15;
    end
    nxt = m_owner;
    if (!m_armed) nxt = -1;
    else if (m_owner < 0) nxt = (r[0] && r[1]) ? 1 - m_last : r[0] ? 0 : r[1] ? 1 : -1;
    else if (!r[m_owner]) nxt = r[1 - m_owner] ? 1 - m_owner : -1;
    else if (r[1 - m_owner] && m_run >= MAX_HOLD) nxt = 1 - m_owner;
    if (nxt >= 0 && nxt != m_owner) begin
      m_run = 0;
      m_last = nxt;
    end
    m_owner = nxt;
    m_armed = 1'b1;
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    logic [7:0] ea, ed;
    logic       ew;
    ea = 8'h00; ed = 8'h00; ew = 1'b0;
    if (m_owner == 0 && req0) begin ea = addr0; ew = we0; ed = wdata0; end
    if (m_owner == 1 && req1) begin ea = addr1; ew = we1; ed = wdata1; end
    check("gnt0", 32'(gnt0), 32'(m_owner == 0));
    check("gnt1", 32'(gnt1), 32'(m_owner == 1));
    check("mutex", 32'(gnt0 & gnt1), 0);
    check("rdValid0", 32'(rdValid0), 32'(m_rdv[0]));
    check("rdValid1", 32'(rdValid1), 32'(m_rdv[1]));
    check("rdata", 32'(rdata), 32'(m_rdata));
    check("memAddr", 32'(memAddr), 32'(ea));
    check("memWe", 32'(memWe), 32'(ew));
    check("memWdata", 32'(memWdata), 32'(ed));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_cmd(input int i);
    if (i == 0) begin
      addr0 = 8'($urandom_range(0, 15)); we0 = 1'($urandom_range(0, 1)); wdata0 = 8'($urandom);
    end else begin
      addr1 = 8'($urandom_range(0, 15)); we1 = 1'($urandom_range(0, 1)); wdata1 = 8'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h2A] = 8'h5C;
    ref_mem[8'h2A] = 8'h5C;

    repeat (3) cycle();
    check("rst_gnt0", 32'(gnt0), 0);
    check("rst_rdValid0", 32'(rdValid0), 0);
    check("rst_rdata", 32'(rdata), 0);

    req0 = 1'b1; addr0 = 8'h2A; we0 = 1'b0;
    req1 = 1'b1; addr1 = 8'h80; we1 = 1'b1; wdata1 = 8'hFF;
    @(negedge clk);
    #1 rst = 1'b0;
    cycle();
    check("first_edge_gnt0", 32'(gnt0), 0);
    check("first_edge_gnt1", 32'(gnt1), 0);
    cycle();
    check("tie_gnt0", 32'(gnt0), 1);
    check("tie_gnt1", 32'(gnt1), 0);
    check("read_memAddr", 32'(memAddr), 32'h2A);
    check("read_memWe", 32'(memWe), 0);

    for (int k = 0; k < 16; k++) begin
      check("hold_gnt0", 32'(gnt0), 32'(((k / 4) % 2) == 0));
      check("hold_gnt1", 32'(gnt1), 32'(((k / 4) % 2) == 1));
      if (k == 1) begin
        check("read_rdata", 32'(rdata), 32'h5C);
        check("read_rdValid0", 32'(rdValid0), 1);
        check("read_rdValid1", 32'(rdValid1), 0);
      end
      if (k == 4) begin
        check("write_memWe", 32'(memWe), 1);
        check("write_memAddr", 32'(memAddr), 32'h80);
        check("write_memWdata", 32'(memWdata), 32'hFF);
      end
      if (k == 5) begin
        check("write_rdValid1", 32'(rdValid1), 0);
        check("write_rdata", 32'(rdata), 32'h5C);
      end
      cycle();
    end
    check("hold_wrap_gnt0", 32'(gnt0), 1);

    req1 = 1'b0;
    cycle();
    req0 = 1'b0; req1 = 1'b1;
    #1 check("release_memAddr", 32'(memAddr), 0);
    cycle();
    check("handover_gnt1", 32'(gnt1), 1);
    check("handover_gnt0", 32'(gnt0), 0);
    req1 = 1'b0;
    cycle();
    check("idle_gnt1", 32'(gnt1), 0);
    check("idle_memAddr", 32'(memAddr), 0);
    check("idle_memWe", 32'(memWe), 0);

    req0 = 1'b1; addr0 = 8'h2A; we0 = 1'b0;
    for (int t = 0; t < 10 && !gnt0; t++) cycle();
    check("wait_gnt0", 32'(gnt0), 1);
    #1 rst = 1'b1;
    #1;
    check("abort_gnt0", 32'(gnt0), 0);
    check("abort_rdValid0", 32'(rdValid0), 0);
    check("abort_rdata", 32'(rdata), 0);
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      cycle();
      check("post_abort_rdValid0", 32'(rdValid0), 0);
    end

    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (m_xfer[0]) begin req0 = ($urandom % 4) != 0; new_cmd(0); end
      else if (!req0 && ($urandom % 3) == 0) begin req0 = 1'b1; new_cmd(0); end
      if (m_xfer[1]) begin req1 = ($urandom % 4) != 0; new_cmd(1); end
      else if (!req1 && ($urandom % 3) == 0) begin req1 = 1'b1; new_cmd(1); end
      if (n % 700 == 350) begin
        #1 rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
